// File: rtl/bru_pkg.sv
// Shared types and default sizing for the branch resolve unit.
package bru_pkg;

  localparam int BRU_DEPTH = 4;
  localparam int BRU_PC_W  = 32;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bru_state_t;

  typedef struct packed {
    logic [BRU_PC_W-1:0] pc;
    logic                pred;
  } bru_entry_t;

endpackage

// File: rtl/bru_pred_fifo.sv
// In-order prediction queue: storage, wrapping pointers, occupancy count and synchronous clear.
module bru_pred_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // a pop in the same cycle frees the slot, so a full queue still accepts the push
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && !clr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves queued IF predictions against ID outcomes, drives predictor updates and fetch redirects.
// Optional BRU_STATS_EN adds saturating branch/mispredict counters.
//
// state | meaning
// RUN   | normal push/pop/compare
// FLUSH | one cycle after a mispredict: queue cleared, IF/ID ignored
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DEPTH = BRU_DEPTH,
  parameter int PC_W  = BRU_PC_W
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IF_Valid,
  input  logic [PC_W-1:0] IF_PC,
  input  logic            IF_Pred,
  input  logic            ID_Valid,
  input  logic [PC_W-1:0] ID_PC,
  input  logic            Is_Branch,
  input  logic            Is_Taken,
  input  logic [PC_W-1:0] Branch_Target,
  output logic            Upd_Valid,
  output logic [PC_W-1:0] Upd_PC,
  output logic            Upd_Taken,
  output logic            Mispredict,
  output logic [PC_W-1:0] Redirect_PC,
  output logic            Q_Full,
  output logic            Desync
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]     Branch_Cnt,
  output logic [31:0]     Mispred_Cnt
`endif
);

  bru_state_t      state, state_nxt;
  logic [PC_W:0]   head;
  logic [PC_W-1:0] head_pc;
  logic            head_pred;
  logic            q_empty;
  logic            run;
  logic            pop_ok;
  logic [PC_W-1:0] pc_plus4;

  logic            upd_valid_nxt;
  logic [PC_W-1:0] upd_pc_nxt;
  logic            upd_taken_nxt;
  logic            mispred_nxt;
  logic [PC_W-1:0] redirect_nxt;
  logic            desync_hit;

  assign run       = (state == RUN);
  assign pop_ok    = run && ID_Valid && !q_empty;
  assign head_pc   = head[PC_W:1];
  assign head_pred = head[0];
  assign pc_plus4  = ID_PC + PC_W'(4);

  bru_pred_fifo #(
    .DEPTH (DEPTH),
    .W     (PC_W + 1)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (state == FLUSH),
    .push  (run && IF_Valid),
    .pop   (run && ID_Valid),
    .wdata ({IF_PC, IF_Pred}),
    .rdata (head),
    .full  (Q_Full),
    .empty (q_empty)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    upd_valid_nxt = 1'b0;
    upd_pc_nxt    = '0;
    upd_taken_nxt = 1'b0;
    mispred_nxt   = 1'b0;
    redirect_nxt  = '0;
    desync_hit    = 1'b0;
    case (state)
      RUN: begin
        if (pop_ok) begin
          if (head_pc != ID_PC) begin
            // queue lost track of the instruction stream: refetch after it
            desync_hit    = 1'b1;
            mispred_nxt   = 1'b1;
            redirect_nxt  = pc_plus4;
            upd_valid_nxt = Is_Branch;
          end else if (Is_Branch) begin
            upd_valid_nxt = 1'b1;
            mispred_nxt   = (head_pred != Is_Taken);
            redirect_nxt  = Is_Taken ? Branch_Target : pc_plus4;
          end else begin
            mispred_nxt   = head_pred;
            redirect_nxt  = pc_plus4;
          end
          if (upd_valid_nxt) begin
            upd_pc_nxt    = ID_PC;
            upd_taken_nxt = Is_Taken;
          end
          if (!mispred_nxt) redirect_nxt = '0;
          if (mispred_nxt)  state_nxt    = FLUSH;
        end
      end
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Upd_Valid   <= 1'b0;
      Upd_PC      <= '0;
      Upd_Taken   <= 1'b0;
      Mispredict  <= 1'b0;
      Redirect_PC <= '0;
      Desync      <= 1'b0;
    end else begin
      Upd_Valid   <= upd_valid_nxt;
      Upd_PC      <= upd_pc_nxt;
      Upd_Taken   <= upd_taken_nxt;
      Mispredict  <= mispred_nxt;
      Redirect_PC <= redirect_nxt;
      Desync      <= Desync | desync_hit;
    end
  end

`ifdef BRU_STATS_EN
  // counters step on the same edge that raises the matching strobe
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Branch_Cnt  <= '0;
      Mispred_Cnt <= '0;
    end else begin
      if (upd_valid_nxt && (Branch_Cnt != '1)) Branch_Cnt  <= Branch_Cnt + 1'b1;
      if (mispred_nxt && (Mispred_Cnt != '1))  Mispred_Cnt <= Mispred_Cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (default build; BRU_STATS_EN adds counter checks).
module tb_branch_resolve_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IF_Valid;
  logic [31:0] IF_PC;
  logic        IF_Pred;
  logic        ID_Valid;
  logic [31:0] ID_PC;
  logic        Is_Branch;
  logic        Is_Taken;
  logic [31:0] Branch_Target;
  logic        Upd_Valid;
  logic [31:0] Upd_PC;
  logic        Upd_Taken;
  logic        Mispredict;
  logic [31:0] Redirect_PC;
  logic        Q_Full;
  logic        Desync;
`ifdef BRU_STATS_EN
  logic [31:0] Branch_Cnt;
  logic [31:0] Mispred_Cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  branch_resolve_unit #(.DEPTH(4), .PC_W(32)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .IF_Valid      (IF_Valid),
    .IF_PC         (IF_PC),
    .IF_Pred       (IF_Pred),
    .ID_Valid      (ID_Valid),
    .ID_PC         (ID_PC),
    .Is_Branch     (Is_Branch),
    .Is_Taken      (Is_Taken),
    .Branch_Target (Branch_Target),
    .Upd_Valid     (Upd_Valid),
    .Upd_PC        (Upd_PC),
    .Upd_Taken     (Upd_Taken),
    .Mispredict    (Mispredict),
    .Redirect_PC   (Redirect_PC),
    .Q_Full        (Q_Full),
    .Desync        (Desync)
`ifdef BRU_STATS_EN
    ,
    .Branch_Cnt    (Branch_Cnt),
    .Mispred_Cnt   (Mispred_Cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    IF_Valid = 1'b0; IF_PC = '0; IF_Pred = 1'b0;
    ID_Valid = 1'b0; ID_PC = '0; Is_Branch = 1'b0; Is_Taken = 1'b0; Branch_Target = '0;
  endtask

  task automatic push(input logic [31:0] pc, input logic pred);
    IF_Valid = 1'b1; IF_PC = pc; IF_Pred = pred;
  endtask

  task automatic id(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] tgt);
    ID_Valid = 1'b1; ID_PC = pc; Is_Branch = br; Is_Taken = tk; Branch_Target = tgt;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".upd_valid"}, {31'b0, Upd_Valid}, 32'd0);
    check({tag, ".mispredict"}, {31'b0, Mispredict}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".upd_valid"}, {31'b0, Upd_Valid}, 32'd0);
    check({tag, ".upd_pc"}, Upd_PC, 32'd0);
    check({tag, ".upd_taken"}, {31'b0, Upd_Taken}, 32'd0);
    check({tag, ".mispredict"}, {31'b0, Mispredict}, 32'd0);
    check({tag, ".redirect"}, Redirect_PC, 32'd0);
    check({tag, ".q_full"}, {31'b0, Q_Full}, 32'd0);
    check({tag, ".desync"}, {31'b0, Desync}, 32'd0);
`ifdef BRU_STATS_EN
    check({tag, ".branch_cnt"}, Branch_Cnt, 32'd0);
    check({tag, ".mispred_cnt"}, Mispred_Cnt, 32'd0);
`endif
  endtask

  initial begin
    idle_inputs();
    RESET = 1'b1;
    tick(); tick();
    check_all_zero("reset");
    RESET = 1'b0;

    // fill to full, fifth push dropped
    for (int i = 0; i < 4; i++) begin
      push(32'h100 + 32'(4 * i), 1'b0);
      tick();
      check($sformatf("fill%0d.q_full", i), {31'b0, Q_Full}, (i == 3) ? 32'd1 : 32'd0);
    end
    push(32'h110, 1'b0);
    tick();
    check("drop.q_full", {31'b0, Q_Full}, 32'd1);
    idle_inputs();
    id(32'h100, 1'b0, 1'b0, 32'h0);
    tick();
    check("pop100.q_full", {31'b0, Q_Full}, 32'd0);
    check_quiet("pop100");
    check("pop100.desync", {31'b0, Desync}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      id(32'h100 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
      tick();
      check_quiet($sformatf("drain%0d", i));
      check($sformatf("drain%0d.desync", i), {31'b0, Desync}, 32'd0);
    end
    // empty queue: ID_Valid has no effect
    id(32'h110, 1'b1, 1'b1, 32'h900);
    tick();
    check_quiet("empty_id");
    check("empty_id.desync", {31'b0, Desync}, 32'd0);
    idle_inputs();

    // predicted not-taken, actually taken; push in detection cycle is discarded
    push(32'h200, 1'b0);
    tick();
    idle_inputs();
    id(32'h200, 1'b1, 1'b1, 32'h400);
    push(32'h220, 1'b0);
    tick();
    check("mp200.upd_valid", {31'b0, Upd_Valid}, 32'd1);
    check("mp200.upd_pc", Upd_PC, 32'h200);
    check("mp200.upd_taken", {31'b0, Upd_Taken}, 32'd1);
    check("mp200.mispredict", {31'b0, Mispredict}, 32'd1);
    check("mp200.redirect", Redirect_PC, 32'h400);
    // FLUSH cycle: these inputs are ignored
    push(32'h240, 1'b1);
    id(32'h777, 1'b1, 1'b0, 32'h0);
    tick();
    check_quiet("flush");
    check("flush.desync", {31'b0, Desync}, 32'd0);
    idle_inputs();
    id(32'h220, 1'b1, 1'b1, 32'h0);
    tick();
    check_quiet("post_flush_empty");
    check("post_flush_empty.desync", {31'b0, Desync}, 32'd0);
    idle_inputs();

    // correct taken prediction
    push(32'h300, 1'b1);
    tick();
    idle_inputs();
    id(32'h300, 1'b1, 1'b1, 32'h600);
    tick();
    check("ok300.upd_valid", {31'b0, Upd_Valid}, 32'd1);
    check("ok300.upd_pc", Upd_PC, 32'h300);
    check("ok300.upd_taken", {31'b0, Upd_Taken}, 32'd1);
    check("ok300.mispredict", {31'b0, Mispredict}, 32'd0);
    idle_inputs();

    // predicted taken on a non-branch
    push(32'h380, 1'b1);
    tick();
    idle_inputs();
    id(32'h380, 1'b0, 1'b0, 32'h0);
    tick();
    check("nb380.upd_valid", {31'b0, Upd_Valid}, 32'd0);
    check("nb380.mispredict", {31'b0, Mispredict}, 32'd1);
    check("nb380.redirect", Redirect_PC, 32'h384);
    idle_inputs();
    tick();

    // predicted taken, not taken, at top of address space: redirect wraps to 0
    push(32'hFFFF_FFFC, 1'b1);
    tick();
    idle_inputs();
    id(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h800);
    tick();
    check("wrap.upd_valid", {31'b0, Upd_Valid}, 32'd1);
    check("wrap.upd_taken", {31'b0, Upd_Taken}, 32'd0);
    check("wrap.mispredict", {31'b0, Mispredict}, 32'd1);
    check("wrap.redirect", Redirect_PC, 32'h0);
    idle_inputs();
    tick();

    // desync
    push(32'h500, 1'b0);
    tick();
    idle_inputs();
    id(32'h504, 1'b0, 1'b0, 32'h0);
    tick();
    check("desync.desync", {31'b0, Desync}, 32'd1);
    check("desync.mispredict", {31'b0, Mispredict}, 32'd1);
    check("desync.redirect", Redirect_PC, 32'h508);
    check("desync.upd_valid", {31'b0, Upd_Valid}, 32'd0);
    idle_inputs();
    tick();
    check("desync_sticky", {31'b0, Desync}, 32'd1);
    check("desync_one_cycle", {31'b0, Mispredict}, 32'd0);

    // full queue with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      push(32'h1000 + 32'(4 * i), 1'b0);
      tick();
    end
    check("stream_fill.q_full", {31'b0, Q_Full}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      push(32'h1000 + 32'(4 * (k + 4)), 1'b0);
      id(32'h1000 + 32'(4 * k), 1'b0, 1'b0, 32'h0);
      tick();
      check($sformatf("stream%0d.q_full", k), {31'b0, Q_Full}, 32'd1);
      check($sformatf("stream%0d.mispredict", k), {31'b0, Mispredict}, 32'd0);
    end
    idle_inputs();

    // mispredict leaving 3 entries queued, then reset during FLUSH
    id(32'h1028, 1'b1, 1'b1, 32'hA00);
    tick();
    check("pre_rst.mispredict", {31'b0, Mispredict}, 32'd1);
    idle_inputs();
    #2;
    RESET = 1'b1;
    #1;
    check_all_zero("rst_in_flush");
    tick();
    RESET = 1'b0;
    id(32'h102C, 1'b0, 1'b0, 32'h0);
    tick();
    check_quiet("after_rst_empty");
    check("after_rst_empty.desync", {31'b0, Desync}, 32'd0);
    idle_inputs();
    push(32'h2000, 1'b0);
    tick();
    idle_inputs();
    id(32'h2000, 1'b1, 1'b0, 32'h0);
    tick();
    check("after_rst_run.upd_valid", {31'b0, Upd_Valid}, 32'd1);
    check("after_rst_run.upd_pc", Upd_PC, 32'h2000);
    check("after_rst_run.mispredict", {31'b0, Mispredict}, 32'd0);
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolution and update end of the branch-prediction interface.
- Records every prediction issued at IF in an in-order queue, then pops one entry per instruction reaching ID.
- Compares the recorded prediction with the actual outcome and drives the predictor history update (PC, valid, taken).
- On a wrong prediction, raises a one-cycle mispredict/redirect to the fetch stage and flushes all younger queued predictions.

Parameters:
- DEPTH, 4, prediction queue entries (power of 2, >=2)
- PC_W, 32, PC width

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- IF_Valid  in  1  a fetched instruction and its prediction are presented this cycle
- IF_PC  in  PC_W  PC of that fetch
- IF_Pred  in  1  prediction given for IF_PC (1 = taken)
- ID_Valid  in  1  an instruction is in ID this cycle; pops the queue head
- ID_PC  in  PC_W  PC of the ID instruction
- Is_Branch  in  1  ID instruction is a conditional branch
- Is_Taken  in  1  resolved direction
- Branch_Target  in  PC_W  resolved taken target
- Upd_Valid  out  1  predictor history update strobe
- Upd_PC  out  PC_W  PC whose history is shifted
- Upd_Taken  out  1  bit shifted into that history
- Mispredict  out  1  redirect fetch and kill younger instructions
- Redirect_PC  out  PC_W  correct next fetch PC
- Q_Full  out  1  queue full; IF must stall
- Desync  out  1  sticky: head PC differed from ID_PC

Behaviour:
- Reset: all outputs 0, queue empty, read and write pointers 0, state RUN. Reset mid-flush returns to RUN with an empty queue.
- Queue entry is {pc, pred}. Push when IF_Valid and not full and state==RUN. Pop when ID_Valid and not empty.
- Simultaneous push and pop is allowed in the same cycle, including when full: the count is unchanged and the push is accepted.
- Push while full without a pop: the push is dropped and the queue is unchanged. Q_Full is combinational from count==DEPTH.
- ID_Valid while empty: no pop, no update, no mispredict.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Pop with head.pc != ID_PC: set Desync, treat as a mispredict with Redirect_PC = ID_PC+4, and assert Upd_Valid only if Is_Branch.
- Pop with Is_Branch=1: registered one cycle later, Upd_Valid=1, Upd_PC=ID_PC, Upd_Taken=Is_Taken.
- If that branch's head.pred != Is_Taken: Mispredict=1 for exactly one cycle, same cycle as Upd_Valid.
  - Redirect_PC = Branch_Target when taken, else ID_PC+4 (modulo 2^PC_W).
- Pop with Is_Branch=0: no update. If head.pred=1 (predicted taken on a non-branch), raise Mispredict with Redirect_PC=ID_PC+4.
- All outputs are registered; latency from ID inputs to outputs is 1 cycle.
- FSM:
  - RUN --mispredict detected--> FLUSH.
  - FLUSH (1 cycle): queue cleared (pointers and count to 0), all IF pushes and ID pops ignored, Upd_Valid=0 --> RUN.
- Pushes in the detection cycle are discarded, since the flush clears the queue.
- Back-to-back ID_Valid during FLUSH is ignored; those instructions are killed by the redirect.

Optional Feature:
- Macro BRU_STATS_EN.
- Defined: adds output ports Branch_Cnt[31:0] and Mispred_Cnt[31:0].
  - Branch_Cnt increments on each Upd_Valid; Mispred_Cnt increments on each Mispredict.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and counters absent; functional behaviour identical.

Decomposition:
- Package bru_pkg: bru_entry_t {pc, pred}, bru_state_t {RUN, FLUSH}, default DEPTH and PC_W constants.
- Sub-module bru_pred_fifo holds the storage, pointers, count, full/empty and synchronous clear. The top level owns the compare logic, FSM, outputs and stats.

Test Plan:
- Push 4 entries (PC 0x100..0x10C, pred=0) with no pops -> Q_Full=1. Fifth push dropped. Pop 0x100 -> Q_Full=0.
- Push {0x200, pred 0}; ID 0x200 Is_Branch=1 Is_Taken=1 target 0x400 -> next cycle Upd_Valid=1, Upd_PC=0x200, Upd_Taken=1, Mispredict=1, Redirect_PC=0x400. One FLUSH cycle, queue empty.
- Push {0x300, pred 1}; ID 0x300 Is_Branch=1 Is_Taken=1 -> Upd_Valid=1, Mispredict=0.
- Push {0x500, pred 0}; ID 0x504 -> Desync=1, Mispredict=1, Redirect_PC=0x508.
- Full queue with simultaneous push and pop for 10 cycles -> count stays 4, pointers wrap, pops return entries in push order.
- Assert RESET during FLUSH with 3 queued entries -> all outputs 0, queue empty, state RUN. Stats counters are 0 when BRU_STATS_EN is defined.
